mem_arbiter: RTL and testbench

//  Shares the single RAM port between the instruction cache and the data cache.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_arb_watchdog.sv | 29 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state, and memory arbiter grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } arb_state_t;

    localparam int    ARB_TIMEOUT_DEFAULT  = 255;
    localparam word_t ARB_ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating grant-cycle counter. Flags expiry once TIMEOUT cycles pass without a RAM access.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int             W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]   TC = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != TC)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TC);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache, with a watchdog abort.
// Optional round-robin tie-break enabled by defining ARB_RR_EN (default: dcache priority).
//
// state  | meaning
// IDLE   | no owner; RAM idle; turnaround cycle after every grant
// IGRANT | icache owns the RAM port (read)
// DGRANT | dcache owns the RAM port (read or write)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT  = ARB_TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_WORD = ARB_ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    arb_state_t state, next_state;
    ramstate_t  rs;

    logic d_req;
    logic granted;
    logic owner_req;
    logic access;
    logic done;
    logic abort;
    logic expired;
    logic pick_d;

    assign rs        = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign granted   = (state != IDLE);
    assign owner_req = ((state == IGRANT) & iREN) | ((state == DGRANT) & d_req);
    assign access    = (rs == ACCESS);
    assign done      = owner_req & access;
    // A completed access beats a simultaneous watchdog expiry.
    assign abort     = owner_req & ~access & ((rs == ERROR) | expired);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clr     (~granted),
        .inc     (granted & ~access),
        .expired (expired)
    );

`ifdef ARB_RR_EN
    logic last_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (done | abort) begin
            last_d <= (state == DGRANT);
        end
    end

    assign pick_d = d_req & (~iREN | ~last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            arb_err <= 1'b0;
        end else if (abort) begin
            arb_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT, DGRANT: begin
                // Dropped request, completion and abort all return through IDLE.
                if (!owner_req || done || abort) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        case (state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = abort ? ERR_WORD : ramload;
            end
            DGRANT: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = abort ? ERR_WORD : ramload;
            end
            default: ;
        endcase
        iwait = iREN  & ~((state == IGRANT) & (done | abort));
        dwait = d_req & ~((state == DGRANT) & (done | abort));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow ARB_RR_EN if it is defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .TIMEOUT  (255),
        .ERR_WORD (32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .arb_err  (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        chk("rst_arb_err", {31'b0, arb_err}, 32'd0);
        next();
        nRST = 1'b1;
    endtask

    initial begin
        logic exp_d;

        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = BUSY;

        // 1: reset state, then icache read with two BUSY cycles
        #1;
        chk("rst_iwait",   {31'b0, iwait},   32'd1);
        chk("rst_dwait",   {31'b0, dwait},   32'd0);
        chk("rst_ramREN",  {31'b0, ramREN},  32'd0);
        chk("rst_arb_err", {31'b0, arb_err}, 32'd0);
        next(); next();
        nRST = 1'b1;
        #1 chk("t1_c0_ramREN", {31'b0, ramREN}, 32'd0);
        next();
        #1 chk("t1_c1_ramREN", {31'b0, ramREN}, 32'd1);
        chk("t1_c1_ramaddr", ramaddr, 32'h40);
        chk("t1_c1_iwait", {31'b0, iwait}, 32'd1);
        next();
        #1 chk("t1_c2_iwait", {31'b0, iwait}, 32'd1);
        next();
        ramstate = ACCESS; ramload = 32'h12345678;
        #1 chk("t1_c3_iwait", {31'b0, iwait}, 32'd0);
        chk("t1_c3_iload", iload, 32'h12345678);
        chk("t1_c3_dload", dload, 32'h0);
        next();
        iREN = 1'b0; ramstate = FREE;
        #1 chk("t1_c4_ramREN", {31'b0, ramREN}, 32'd0);
        chk("t1_c4_ramaddr", ramaddr, 32'h0);

        // 2: simultaneous iREN + dWEN, dcache served first
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        ramstate = BUSY;
        #1 chk("t2_c0_dwait", {31'b0, dwait}, 32'd1);
        next();
        #1 chk("t2_dg_ramWEN", {31'b0, ramWEN}, 32'd1);
        chk("t2_dg_ramREN", {31'b0, ramREN}, 32'd0);
        chk("t2_dg_ramaddr", ramaddr, 32'h100);
        chk("t2_dg_ramstore", ramstore, 32'hDEADBEEF);
        ramstate = ACCESS;
        #1 chk("t2_dg_dwait", {31'b0, dwait}, 32'd0);
        chk("t2_dg_iwait", {31'b0, iwait}, 32'd1);
        next();
        dWEN = 1'b0; ramstate = BUSY;
        #1 chk("t2_turn_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("t2_turn_iwait", {31'b0, iwait}, 32'd1);
        next();
        #1 chk("t2_ig_ramaddr", ramaddr, 32'h80);
        chk("t2_ig_iwait", {31'b0, iwait}, 32'd1);
        ramstate = ACCESS; ramload = 32'hCAFEF00D;
        #1 chk("t2_ig_done_iwait", {31'b0, iwait}, 32'd0);
        chk("t2_ig_iload", iload, 32'hCAFEF00D);
        next();
        iREN = 1'b0; ramstate = FREE;
        #1 chk("t2_idle_ramREN", {31'b0, ramREN}, 32'd0);

        // 3: both caches requesting continuously; last served was icache
        iREN = 1'b1; dWEN = 1'b1; ramstate = ACCESS; ramload = 32'h77;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            next();
            #1 chk($sformatf("t3_g%0d_ramWEN", g), {31'b0, ramWEN}, {31'b0, exp_d});
            chk($sformatf("t3_g%0d_ramaddr", g), ramaddr, exp_d ? 32'h100 : 32'h80);
            next();
            if (g == 3) begin
                iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
            end
            #1 chk($sformatf("t3_g%0d_idle", g), {30'b0, ramREN, ramWEN}, 32'd0);
        end

        // 4: dcache read stuck BUSY until watchdog expiry
        dREN = 1'b1; daddr = 32'h200; ramstate = BUSY;
        next();
        #1 chk("t4_g0_ramREN", {31'b0, ramREN}, 32'd1);
        repeat (254) next();
        #1 chk("t4_g254_dwait", {31'b0, dwait}, 32'd1);
        chk("t4_g254_arb_err", {31'b0, arb_err}, 32'd0);
        next();
        #1 chk("t4_g255_dwait", {31'b0, dwait}, 32'd0);
        chk("t4_g255_dload", dload, 32'hBAD1BAD1);
        next();
        dREN = 1'b0;
        #1 chk("t4_post_arb_err", {31'b0, arb_err}, 32'd1);
        chk("t4_post_ramREN", {31'b0, ramREN}, 32'd0);
        iREN = 1'b1; iaddr = 32'h44;
        next();
        ramstate = ACCESS; ramload = 32'h55;
        #1 chk("t4_i_ramaddr", ramaddr, 32'h44);
        chk("t4_i_iwait", {31'b0, iwait}, 32'd0);
        chk("t4_i_iload", iload, 32'h55);
        next();
        iREN = 1'b0; ramstate = FREE;
        #1 chk("t4_sticky_arb_err", {31'b0, arb_err}, 32'd1);

        // 5: ERROR during IGRANT
        do_reset();
        iREN = 1'b1; iaddr = 32'h60; ramstate = BUSY;
        next();
        #1 chk("t5_ig_iwait", {31'b0, iwait}, 32'd1);
        ramstate = ERROR;
        #1 chk("t5_err_iwait", {31'b0, iwait}, 32'd0);
        chk("t5_err_iload", iload, 32'hBAD1BAD1);
        chk("t5_err_arb_err_pre", {31'b0, arb_err}, 32'd0);
        next();
        iREN = 1'b0; ramstate = FREE;
        #1 chk("t5_arb_err", {31'b0, arb_err}, 32'd1);
        chk("t5_idle_ramREN", {31'b0, ramREN}, 32'd0);

        // 6: dcache drops its request mid-grant, then reset mid-grant
        do_reset();
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        next();
        #1 chk("t6_dg_ramREN", {31'b0, ramREN}, 32'd1);
        dREN = 1'b0;
        #1 chk("t6_drop_dwait", {31'b0, dwait}, 32'd0);
        next();
        #1 chk("t6_idle_ramREN", {31'b0, ramREN}, 32'd0);
        chk("t6_idle_ramaddr", ramaddr, 32'h0);
        chk("t6_arb_err", {31'b0, arb_err}, 32'd0);
        dWEN = 1'b1; daddr = 32'h304; dstore = 32'h1111;
        next();
        #1 chk("t6_dg2_ramWEN", {31'b0, ramWEN}, 32'd1);
        #2 nRST = 1'b0;
        #1 chk("t6_rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("t6_rst_ramaddr", ramaddr, 32'h0);
        chk("t6_rst_ramstore", ramstore, 32'h0);
        chk("t6_rst_dwait", {31'b0, dwait}, 32'd1);
        dWEN = 1'b0;
        next();
        nRST = 1'b1;
        #1 chk("t6_after_ramWEN", {31'b0, ramWEN}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
